// File: rtl/async_fifo_ga.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_ga
// Brief    : Gray-pointer FIFO with two-flop pointer synchronizers, run from a
//            single clock so flag latencies match the dual-clock deskew slot.
// Revision : 1.0 - initial release
// ============================================================================
module async_fifo_ga #(
    parameter int DSIZE = 10,
    parameter int ASIZE = 4
) (
    input  logic             i_uniform_clk,
    input  logic             i_u_unif_rst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             o_overflow,
    output logic             o_underflow,
    output logic [ASIZE:0]   o_wr_cnt
);

    localparam int DEPTH = 1 << ASIZE;

    // ------------------------------------------------------------------
    // Storage (not reset; stale words are hidden behind rempty)
    // ------------------------------------------------------------------
    logic [DSIZE-1:0] mem_q [DEPTH];

    // Write-side state
    logic [ASIZE:0] wbin_q,  wbin_d;
    logic [ASIZE:0] wgray_q, wgray_d;
    logic [ASIZE:0] wq1_rgray_q, wq2_rgray_q;
    logic           wfull_q, wfull_d;
    logic [ASIZE:0] wr_cnt_q, wr_cnt_d;

    // Read-side state
    logic [ASIZE:0] rbin_q,  rbin_d;
    logic [ASIZE:0] rgray_q, rgray_d;
    logic [ASIZE:0] rq1_wgray_q, rq2_wgray_q;
    logic           rempty_q, rempty_d;

    logic           w_wr_en;
    logic           w_rd_en;
    logic [ASIZE:0] w_full_cmp;

    function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    // ------------------------------------------------------------------
    // Write side next-state
    // ------------------------------------------------------------------
    assign w_wr_en = winc && !wfull_q;

    // Full when the write pointer is one lap ahead: top two gray bits differ.
    assign w_full_cmp = {~wq2_rgray_q[ASIZE:ASIZE-1], wq2_rgray_q[ASIZE-2:0]};

    always_comb begin
        wbin_d   = wbin_q + {{ASIZE{1'b0}}, w_wr_en};
        wgray_d  = bin2gray(wbin_d);
        wfull_d  = (wgray_d == w_full_cmp);
        wr_cnt_d = wr_cnt_q;
        if (w_wr_en && (wr_cnt_q != {(ASIZE+1){1'b1}})) begin
            wr_cnt_d = wr_cnt_q + {{ASIZE{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge i_uniform_clk) begin
        if (!i_u_unif_rst_n) begin
            wbin_q      <= '0;
            wgray_q     <= '0;
            wq1_rgray_q <= '0;
            wq2_rgray_q <= '0;
            wfull_q     <= 1'b0;
            wr_cnt_q    <= '0;
        end else begin
            wbin_q      <= wbin_d;
            wgray_q     <= wgray_d;
            wq1_rgray_q <= rgray_q;
            wq2_rgray_q <= wq1_rgray_q;
            wfull_q     <= wfull_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    always_ff @(posedge i_uniform_clk) begin
        if (w_wr_en) begin
            mem_q[wbin_q[ASIZE-1:0]] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read side next-state
    // ------------------------------------------------------------------
    assign w_rd_en = rinc && !rempty_q;

    always_comb begin
        rbin_d   = rbin_q + {{ASIZE{1'b0}}, w_rd_en};
        rgray_d  = bin2gray(rbin_d);
        rempty_d = (rgray_d == rq2_wgray_q);
    end

    always_ff @(posedge i_uniform_clk) begin
        if (!i_u_unif_rst_n) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            rq1_wgray_q <= '0;
            rq2_wgray_q <= '0;
            rempty_q    <= 1'b1;
        end else begin
            rbin_q      <= rbin_d;
            rgray_q     <= rgray_d;
            rq1_wgray_q <= wgray_q;
            rq2_wgray_q <= rq1_wgray_q;
            rempty_q    <= rempty_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rdata       = mem_q[rbin_q[ASIZE-1:0]];
    assign wfull       = wfull_q;
    assign rempty      = rempty_q;
    assign o_overflow  = winc && wfull_q;
    assign o_underflow = rinc && rempty_q;
    assign o_wr_cnt    = wr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_ga.sv
`default_nettype none
// ============================================================================
// Module   : tb_async_fifo_ga
// Brief    : Directed self-checking bench for async_fifo_ga (DSIZE=10, ASIZE=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_async_fifo_ga;

    localparam int DSIZE = 10;
    localparam int ASIZE = 4;

    logic             clk;
    logic             rst_n;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             ovf;
    logic             udf;
    logic [ASIZE:0]   wr_cnt;

    int n_checks;
    int n_errors;

    async_fifo_ga #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_dut (
        .i_uniform_clk  (clk),
        .i_u_unif_rst_n (rst_n),
        .winc           (winc),
        .wdata          (wdata),
        .wfull          (wfull),
        .rinc           (rinc),
        .rdata          (rdata),
        .rempty         (rempty),
        .o_overflow     (ovf),
        .o_underflow    (udf),
        .o_wr_cnt       (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int sent;
        int rcv;
        int ovf_seen;
        int udf_seen;
        int cyc;

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        winc  = 1'b1;
        rinc  = 1'b1;
        wdata = 10'h111;

        // Reset with both requests held high
        tick();
        tick();
        check_eq("rst_rempty", rempty, 1);
        check_eq("rst_wfull",  wfull,  0);
        check_eq("rst_wrcnt",  wr_cnt, 0);
        winc  = 1'b0;
        rinc  = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check_eq("post_rst_wrcnt",  wr_cnt, 0);
        check_eq("post_rst_rempty", rempty, 1);

        // Single word latency
        winc  = 1'b1;
        wdata = 10'h2A5;
        tick();
        winc = 1'b0;
        check_eq("single_empty_n0", rempty, 1);
        tick();
        check_eq("single_empty_n1", rempty, 1);
        tick();
        check_eq("single_empty_n2", rempty, 1);
        tick();
        check_eq("single_empty_n3", rempty, 0);
        check_eq("single_rdata",    rdata,  10'h2A5);
        check_eq("single_wrcnt",    wr_cnt, 1);
        rinc = 1'b1;
        #1;
        check_eq("single_no_udf", udf, 0);
        tick();
        rinc = 1'b0;
        check_eq("single_empty_after_rd", rempty, 1);

        // Fill from a clean reset so o_wr_cnt counts only these writes
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            winc  = 1'b1;
            wdata = DSIZE'(i);
            tick();
            if (i == 14) check_eq("fill_not_full_15", wfull, 0);
        end
        check_eq("fill_full",   wfull,  1);
        check_eq("fill_wrcnt",  wr_cnt, 16);
        check_eq("fill_rempty", rempty, 0);
        wdata = 10'h3FF;
        #1;
        check_eq("ovf_pulse", ovf, 1);
        tick();
        winc = 1'b0;
        #1;
        check_eq("ovf_clear",     ovf,    0);
        check_eq("ovf_wrcnt",     wr_cnt, 16);
        check_eq("ovf_still_full", wfull, 1);

        // Drain in order; full drops three edges after the first read
        for (int k = 0; k < 16; k++) begin
            rinc = 1'b1;
            check_eq($sformatf("drain_data_%0d", k), rdata, k);
            tick();
            if (k < 3)  check_eq($sformatf("drain_full_%0d", k), wfull, 1);
            if (k == 3) check_eq("drain_full_clear", wfull, 0);
        end
        rinc = 1'b0;
        check_eq("drain_empty", rempty, 1);

        // Underflow and recovery
        rinc = 1'b1;
        #1;
        check_eq("udf_pulse", udf, 1);
        tick();
        rinc = 1'b0;
        #1;
        check_eq("udf_clear", udf, 0);
        winc  = 1'b1;
        wdata = 10'h1C3;
        tick();
        winc = 1'b0;
        w = 0;
        while (rempty && w < 10) begin
            tick();
            w++;
        end
        check_eq("udf_recover_lat",   w,     3);
        check_eq("udf_recover_rdata", rdata, 10'h1C3);
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        check_eq("udf_recover_empty", rempty, 1);

        // Streaming with concurrent reads across several pointer wraps
        sent = 0;
        rcv = 0;
        ovf_seen = 0;
        udf_seen = 0;
        cyc = 0;
        while (rcv < 100 && cyc < 400) begin
            winc  = (sent < 100);
            wdata = DSIZE'(sent);
            rinc  = !rempty;
            #1;
            if (ovf) ovf_seen++;
            if (udf) udf_seen++;
            if (winc && !wfull) sent++;
            if (rinc && !rempty) begin
                check_eq($sformatf("stream_%0d", rcv), rdata, rcv);
                rcv++;
            end
            tick();
            cyc++;
        end
        winc = 1'b0;
        rinc = 1'b0;
        check_eq("stream_count", rcv,      100);
        check_eq("stream_ovf",   ovf_seen, 0);
        check_eq("stream_udf",   udf_seen, 0);
        check_eq("stream_wrcnt_sat", wr_cnt, 31);

        // Reset mid-stream with 7 words buffered
        for (int i = 0; i < 7; i++) begin
            winc  = 1'b1;
            wdata = DSIZE'(10'h100 + i);
            tick();
        end
        winc = 1'b0;
        tick();
        tick();
        tick();
        check_eq("mid_buffered", rempty, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("mid_rst_rempty", rempty, 1);
        check_eq("mid_rst_wfull",  wfull,  0);
        check_eq("mid_rst_wrcnt",  wr_cnt, 0);
        winc  = 1'b1;
        wdata = 10'h055;
        tick();
        winc = 1'b0;
        w = 0;
        while (rempty && w < 10) begin
            tick();
            w++;
        end
        check_eq("mid_new_lat",   w,      3);
        check_eq("mid_new_rdata", rdata,  10'h055);
        check_eq("mid_new_wrcnt", wr_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
